// File: rtl/axis_frame_rr_arbiter.sv
// axis_frame_rr_arbiter
//   Frame-granular round-robin arbiter. It shares one AXI4-Stream sink between
//   S_COUNT source streams. One source is granted at a time, and the grant is
//   held until that source's tlast beat is accepted.
//
// Ports
//   clk, rst                 single clock; rst is synchronous and active-high
//   s_axis_t*                packed per-port streams, port i at [i*W +: W]
//   s_axis_tready            per-port ready; only the granted port sees m_axis_tready
//   m_axis_t*                shared output stream (combinational mux of the granted port)
//   m_axis_tready            output ready
//   port_enable              0 = port is never granted (a frame in flight is unaffected)
//   grant_valid              a frame is in progress
//   grant_index              currently / last granted port

// Per-port slice. When this port holds the grant it forwards its beat and
// valid, and it receives the sink's ready. Otherwise it contributes zeros to
// the OR-mux.
module axis_frame_rr_arbiter_lane #(
  parameter int W = 8
) (
  input  logic         sel,
  input  logic         en,
  input  logic         s_tvalid,
  input  logic         m_tready,
  input  logic [W-1:0] s_beat,
  output logic         req,
  output logic         s_tready,
  output logic         m_tvalid,
  output logic [W-1:0] m_beat
);
  assign req      = s_tvalid & en;
  assign s_tready = sel & m_tready;
  assign m_tvalid = sel & s_tvalid;
  assign m_beat   = sel ? s_beat : '0;
endmodule

module axis_frame_rr_arbiter #(
  parameter int S_COUNT     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
  parameter int ID_WIDTH    = 8,
  parameter int DEST_WIDTH  = 8,
  parameter int USER_WIDTH  = 1,
  parameter int UPDATE_TID  = 0,
  parameter int CL          = (S_COUNT > 2) ? $clog2(S_COUNT) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [S_COUNT*DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0]    s_axis_tkeep,
  input  logic [S_COUNT-1:0]               s_axis_tvalid,
  output logic [S_COUNT-1:0]               s_axis_tready,
  input  logic [S_COUNT-1:0]               s_axis_tlast,
  input  logic [S_COUNT*ID_WIDTH-1:0]      s_axis_tid,
  input  logic [S_COUNT*DEST_WIDTH-1:0]    s_axis_tdest,
  input  logic [S_COUNT*USER_WIDTH-1:0]    s_axis_tuser,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             m_axis_tlast,
  output logic [ID_WIDTH-1:0]              m_axis_tid,
  output logic [DEST_WIDTH-1:0]            m_axis_tdest,
  output logic [USER_WIDTH-1:0]            m_axis_tuser,
  input  logic [S_COUNT-1:0]               port_enable,
  output logic                             grant_valid,
  output logic [CL-1:0]                    grant_index
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  last;
    logic [ID_WIDTH-1:0]   id;
    logic [DEST_WIDTH-1:0] dest;
    logic [USER_WIDTH-1:0] user;
  } beat_t;

  localparam int BEAT_W = $bits(beat_t);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                          state;
  logic [CL-1:0]                   rr_ptr;
  logic                            active;
  logic [S_COUNT-1:0]              req;
  logic [S_COUNT-1:0]              lane_sel;
  logic [S_COUNT-1:0]              lane_vld;
  logic [S_COUNT-1:0][BEAT_W-1:0]  s_beat;
  logic [S_COUNT-1:0][BEAT_W-1:0]  lane_beat;
  logic [BEAT_W-1:0]               mux_vec;
  beat_t                           mux_b;
  logic                            pick_found;
  logic [CL-1:0]                   pick_idx;

  // The output path is closed while rst is high. This keeps readies and
  // valid low on the reset cycle itself, not just on the cycles after it.
  assign active = (state == ACTIVE) && !rst;

  genvar gi;
  generate
    for (gi = 0; gi < S_COUNT; gi++) begin : g_lane
      assign s_beat[gi] = {s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH],
                           s_axis_tkeep[gi*KEEP_WIDTH +: KEEP_WIDTH],
                           s_axis_tlast[gi],
                           s_axis_tid[gi*ID_WIDTH +: ID_WIDTH],
                           s_axis_tdest[gi*DEST_WIDTH +: DEST_WIDTH],
                           s_axis_tuser[gi*USER_WIDTH +: USER_WIDTH]};

      assign lane_sel[gi] = active && (grant_index == CL'(gi));

      axis_frame_rr_arbiter_lane #(.W(BEAT_W)) u_lane (
        .sel      (lane_sel[gi]),
        .en       (port_enable[gi]),
        .s_tvalid (s_axis_tvalid[gi]),
        .m_tready (m_axis_tready),
        .s_beat   (s_beat[gi]),
        .req      (req[gi]),
        .s_tready (s_axis_tready[gi]),
        .m_tvalid (lane_vld[gi]),
        .m_beat   (lane_beat[gi])
      );
    end
  endgenerate

  // At most one lane is selected, so OR-ing the lanes together forms the mux.
  always_comb begin
    mux_vec = '0;
    for (int i = 0; i < S_COUNT; i++) mux_vec = mux_vec | lane_beat[i];
  end

  assign mux_b         = mux_vec;
  assign m_axis_tvalid = |lane_vld;
  assign m_axis_tdata  = mux_b.data;
  assign m_axis_tkeep  = (KEEP_ENABLE != 0) ? mux_b.keep : '1;
  assign m_axis_tlast  = mux_b.last;
  assign m_axis_tid    = (UPDATE_TID != 0) ? ID_WIDTH'(grant_index) : mux_b.id;
  assign m_axis_tdest  = mux_b.dest;
  assign m_axis_tuser  = mux_b.user;

  // Round-robin pick. Search upward from the port after the last one granted,
  // wrapping at S_COUNT. The first requesting port wins.
  always_comb begin
    int idx;
    pick_found = 1'b0;
    pick_idx   = '0;
    idx        = 0;
    for (int off = 1; off <= S_COUNT; off++) begin
      idx = int'(rr_ptr) + off;
      if (idx >= S_COUNT) idx = idx - S_COUNT;
      if (!pick_found && req[idx]) begin
        pick_found = 1'b1;
        pick_idx   = CL'(idx);
      end
    end
  end

  // The grant is decided only in IDLE. The pass through IDLE after each tlast
  // is the single bubble between frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant_valid <= 1'b0;
      grant_index <= '0;
      rr_ptr      <= CL'(S_COUNT - 1);
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_index <= pick_idx;
            rr_ptr      <= pick_idx;
            grant_valid <= 1'b1;
            state       <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
            grant_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          grant_valid <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_frame_rr_arbiter.sv
module tb_axis_frame_rr_arbiter;
  localparam int S   = 4;
  localparam int DW  = 8;
  localparam int KW  = 1;
  localparam int IW  = 8;
  localparam int DSW = 8;
  localparam int UW  = 1;
  localparam int CLW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst;
  logic [S-1:0][DW-1:0]    s_tdata;
  logic [S-1:0][KW-1:0]    s_tkeep;
  logic [S-1:0]            s_tvalid;
  logic [S-1:0]            s_tlast;
  logic [S-1:0][IW-1:0]    s_tid;
  logic [S-1:0][DSW-1:0]   s_tdest;
  logic [S-1:0][UW-1:0]    s_tuser;
  logic                    m_tready;
  logic [S-1:0]            port_en;

  logic [S-1:0]   d0_s_tready, d1_s_tready;
  logic [DW-1:0]  d0_tdata, d1_tdata;
  logic [KW-1:0]  d0_tkeep, d1_tkeep;
  logic           d0_tvalid, d1_tvalid, d0_tlast, d1_tlast;
  logic [IW-1:0]  d0_tid, d1_tid;
  logic [DSW-1:0] d0_tdest, d1_tdest;
  logic [UW-1:0]  d0_tuser, d1_tuser;
  logic           d0_gv, d1_gv;
  logic [CLW-1:0] d0_gidx, d1_gidx;

  axis_frame_rr_arbiter #(.S_COUNT(S), .DATA_WIDTH(DW), .UPDATE_TID(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(d0_s_tready), .s_axis_tlast(s_tlast), .s_axis_tid(s_tid),
    .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
    .m_axis_tdata(d0_tdata), .m_axis_tkeep(d0_tkeep), .m_axis_tvalid(d0_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(d0_tlast), .m_axis_tid(d0_tid),
    .m_axis_tdest(d0_tdest), .m_axis_tuser(d0_tuser),
    .port_enable(port_en), .grant_valid(d0_gv), .grant_index(d0_gidx)
  );

  axis_frame_rr_arbiter #(.S_COUNT(S), .DATA_WIDTH(DW), .UPDATE_TID(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(d1_s_tready), .s_axis_tlast(s_tlast), .s_axis_tid(s_tid),
    .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
    .m_axis_tdata(d1_tdata), .m_axis_tkeep(d1_tkeep), .m_axis_tvalid(d1_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(d1_tlast), .m_axis_tid(d1_tid),
    .m_axis_tdest(d1_tdest), .m_axis_tuser(d1_tuser),
    .port_enable(port_en), .grant_valid(d1_gv), .grant_index(d1_gidx)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: which port owns the sink (-1 = nobody) and who was granted last.
  int m_owner = -1;
  int m_last  = S - 1;
  int m_gidx  = 0;
  logic [S-1:0] hs;

  // Source stimulus state.
  bit [S-1:0] want;
  bit         busy [S];
  int         rem  [S];
  int         fix_len, gap_pct, rdy_pct, en_churn;
  bit         force_id;

  int   order_q[$];
  logic prev_gv = 1'b0;
  logic [IW-1:0] snap_tid1;
  logic [S-1:0]  snap_rdy0;
  logic          snap_gv0;

  task automatic drive();
    for (int i = 0; i < S; i++) begin
      if (hs[i]) begin
        s_tvalid[i] = 1'b0;
        rem[i]--;
        if (rem[i] == 0) busy[i] = 1'b0;
      end
      if (!s_tvalid[i]) begin
        if (!busy[i] && want[i]) begin
          busy[i] = 1'b1;
          rem[i]  = (fix_len > 0) ? fix_len : int'($urandom_range(1, 4));
        end
        if (busy[i] && int'($urandom_range(0, 99)) >= gap_pct) begin
          s_tvalid[i] = 1'b1;
          s_tdata[i]  = DW'($urandom);
          s_tkeep[i]  = KW'($urandom);
          s_tlast[i]  = (rem[i] == 1);
          s_tid[i]    = force_id ? 8'hAA : IW'($urandom);
          s_tdest[i]  = DSW'($urandom);
          s_tuser[i]  = UW'($urandom);
        end
      end
    end
    m_tready = (int'($urandom_range(0, 99)) < rdy_pct);
    if (en_churn > 0 && int'($urandom_range(0, 99)) < en_churn) port_en = S'($urandom);
  endtask

  // One clock: compare at negedge, advance the model, then drive just after posedge.
  task automatic step();
    logic [S-1:0] e_rdy;
    logic         e_vld;
    int           o;
    bit           found;
    @(negedge clk);
    o     = m_owner;
    e_rdy = '0;
    e_vld = 1'b0;
    if (!rst && o >= 0) begin
      e_vld    = s_tvalid[o];
      e_rdy[o] = m_tready;
    end
    chk("s_tready", d0_s_tready, e_rdy);
    chk("m_tvalid", d0_tvalid, e_vld);
    chk("grant_valid", d0_gv, o >= 0);
    chk("grant_index", d0_gidx, m_gidx);
    chk("u1_s_tready", d1_s_tready, e_rdy);
    chk("u1_m_tvalid", d1_tvalid, e_vld);
    chk("u1_grant_valid", d1_gv, o >= 0);
    chk("u1_grant_index", d1_gidx, m_gidx);
    if (e_vld) begin
      chk("tdata", d0_tdata, s_tdata[o]);
      chk("tlast", d0_tlast, s_tlast[o]);
      chk("tid_pass", d0_tid, s_tid[o]);
      chk("tdest", d0_tdest, s_tdest[o]);
      chk("tuser", d0_tuser, s_tuser[o]);
      chk("tkeep_ones", d0_tkeep, {KW{1'b1}});
      chk("u1_tid_port", d1_tid, o);
      chk("u1_tdata", d1_tdata, s_tdata[o]);
      chk("u1_tlast", d1_tlast, s_tlast[o]);
      chk("u1_tdest", d1_tdest, s_tdest[o]);
      chk("u1_tuser", d1_tuser, s_tuser[o]);
      chk("u1_tkeep", d1_tkeep, {KW{1'b1}});
    end
    snap_tid1 = d1_tid;
    snap_rdy0 = d0_s_tready;
    snap_gv0  = d0_gv;
    if (d0_gv && !prev_gv) order_q.push_back(int'(d0_gidx));
    prev_gv = d0_gv;
    hs = e_rdy & s_tvalid;
    if (rst) begin
      m_owner = -1; m_last = S - 1; m_gidx = 0;
    end else if (o >= 0) begin
      if (e_vld && m_tready && s_tlast[o]) m_owner = -1;
    end else begin
      found = 1'b0;
      for (int k = 1; k <= S; k++) begin
        int p;
        p = (m_last + k) % S;
        if (!found && s_tvalid[p] && port_en[p]) begin
          found = 1'b1; m_owner = p; m_last = p; m_gidx = p;
        end
      end
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic do_reset(input int n, input bit all_vld);
    rst = 1'b1;
    for (int i = 0; i < S; i++) begin
      busy[i] = 1'b0; rem[i] = 0;
    end
    s_tvalid = all_vld ? '1 : '0;
    s_tlast  = '0;
    hs       = '0;
    repeat (n) step();
    rst = 1'b0;
  endtask

  task automatic run_frames(input int nframes, input int budget);
    int c;
    c = 0;
    while (order_q.size() < nframes && c < budget) begin
      step();
      c++;
    end
    chk("frame_budget", order_q.size() >= nframes, 1'b1);
  endtask

  initial begin
    int pat4[3];
    bit seen;
    pat4 = '{0, 1, 3};
    rst = 1'b1; s_tvalid = '0; s_tlast = '0; s_tdata = '0; s_tkeep = '0;
    s_tid = '0; s_tdest = '0; s_tuser = '0; m_tready = 1'b1; port_en = '1;
    want = '0; fix_len = 3; gap_pct = 0; rdy_pct = 100; en_churn = 0; force_id = 1'b0;
    hs = '0;
    for (int i = 0; i < S; i++) begin busy[i] = 1'b0; rem[i] = 0; end
    @(posedge clk); #1;

    // Reset with every port requesting: nothing may be granted or accepted.
    do_reset(2, 1'b1);
    rst = 1'b1;
    chk("rst_tready", d0_s_tready, '0);
    chk("rst_gv", d0_gv, 1'b0);
    chk("rst_gidx", d0_gidx, '0);
    do_reset(1, 1'b0);

    // All four ports stream 3-beat frames with the sink always ready.
    want = 4'b1111; fix_len = 3; port_en = 4'b1111;
    do_reset(1, 1'b0); order_q.delete();
    run_frames(8, 200);
    for (int k = 0; k < 8 && k < order_q.size(); k++) chk("rr_order", order_q[k], k % 4);

    // Port 2 is mid-frame when port 1 starts to request.
    want = 4'b0100; fix_len = 4;
    do_reset(1, 1'b0); order_q.delete();
    repeat (3) step();
    want = 4'b0010;
    run_frames(2, 60);
    if (order_q.size() >= 2) begin
      chk("hold_first", order_q[0], 2);
      chk("hold_second", order_q[1], 1);
    end

    // Port 2 is disabled while every port requests.
    want = 4'b1111; fix_len = 2; port_en = 4'b1011;
    do_reset(1, 1'b0); order_q.delete();
    run_frames(9, 200);
    for (int k = 0; k < 9 && k < order_q.size(); k++) chk("en_order", order_q[k], pat4[k % 3]);

    // Random sink backpressure, source gaps, frame lengths and enable changes.
    want = 4'b1111; fix_len = 0; gap_pct = 30; rdy_pct = 60; en_churn = 3; port_en = 4'b1111;
    do_reset(1, 1'b0); order_q.delete();
    repeat (800) step();
    want = S'($urandom) | 4'b0001;
    repeat (700) step();
    chk("rand_frames", order_q.size() > 20, 1'b1);

    // tid rewrite from port 3, then reset in the middle of its frame.
    want = 4'b1000; fix_len = 4; gap_pct = 0; rdy_pct = 100; en_churn = 0;
    force_id = 1'b1; port_en = 4'b1111;
    do_reset(1, 1'b0); order_q.delete();
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      step();
      if (hs[3]) seen = 1'b1;
    end
    chk("tid_beat_seen", seen, 1'b1);
    chk("tid_rewrite", snap_tid1, 8'h03);
    rst = 1'b1;
    busy[3] = 1'b0; rem[3] = 0; s_tvalid = '0;
    hs = '0;
    step();
    chk("midrst_tready", snap_rdy0, '0);
    rst = 1'b0;
    step();
    chk("postrst_tready", snap_rdy0, '0);
    chk("postrst_gv", snap_gv0, 1'b0);
    repeat (20) step();
    force_id = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
